imem_loader: RTL

//  Write-side counterpart to the instruction ROM read path. Accepts a byte stream over a

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 103 ++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input, load control and instruction-memory write bus of the image loader.
// The slave modport is the loader; the master modport is the host/stream source and memory.
interface imem_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 16
);
  logic                     start;
  logic                     abort;
  logic [ADDRESS_WIDTH-1:0] base_addr;
  logic [COUNT_WIDTH-1:0]   num_words;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, abort, base_addr, num_words, byte_valid, byte_data,
    output byte_ready, we, waddr, wdata, busy, done
  );

  modport master (
    output start, abort, base_addr, num_words, byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata, busy, done
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into words and writes them to consecutive
// instruction-memory addresses, holding the CPU via busy during the load.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] waddr_reg, waddr_next;
  logic [DATA_WIDTH-1:0]    wdata_reg, wdata_next;
  logic [COUNT_WIDTH-1:0]   remaining_reg, remaining_next;
  logic [IW-1:0]            idx_reg, idx_next;
  logic [DATA_WIDTH-1:0]    lane_data;

  // Word with the incoming byte dropped into the lane selected by the byte index.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane_data[8*gi +: 8] = (idx_reg == IW'(gi)) ? bus.byte_data
                                                         : wdata_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      remaining_reg <= '0;
      idx_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      waddr_reg     <= waddr_next;
      wdata_reg     <= wdata_next;
      remaining_reg <= remaining_next;
      idx_reg       <= idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    waddr_next     = waddr_reg;
    wdata_next     = wdata_reg;
    remaining_next = remaining_reg;
    idx_next       = idx_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          waddr_next     = {bus.base_addr[ADDRESS_WIDTH-1:2], 2'b00};
          remaining_next = bus.num_words;
          idx_next       = '0;
          state_next     = (bus.num_words == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (bus.byte_valid) begin
          wdata_next = lane_data;
          if (idx_reg == IW'(BYTES - 1)) begin
            idx_next   = '0;
            state_next = WRITE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      WRITE: begin
        // The write strobe is state-decoded, so it still fires in an aborted WRITE cycle.
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          waddr_next     = waddr_reg + ADDRESS_WIDTH'(BYTES);
          remaining_next = remaining_reg - 1'b1;
          idx_next       = '0;
          state_next     = (remaining_reg == COUNT_WIDTH'(1)) ? DONE : COLLECT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.byte_ready = (state_reg == COLLECT);
  assign bus.we         = (state_reg == WRITE);
  assign bus.busy       = (state_reg == COLLECT) || (state_reg == WRITE);
  assign bus.done       = (state_reg == DONE);
  assign bus.waddr      = waddr_reg;
  assign bus.wdata      = wdata_reg;
endmodule
